usb_tx_bus_ctrl: RTL

Sequences ownership of the shared USB D+/D- pair for the device-side transceiver. Arbitrates between the receive path (priority) and the packet encoder, inserts the inter-packet turnaround delay, hands the bus to the encoder, then generates the End-of-Packet (SE0, SE0, J) itself before releasing the lines. Drives the direction-select inputs (`transmitting`, `transmit_eop`) and the `d_plus_out`/`d_minus_out` line values of the transceiver selector.

---
 rtl/usb_tx_bus_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/usb_tx_bus_ctrl.sv
// usb_tx_bus_ctrl: owns the shared USB D+/D- pair for the device transmitter.
// Yields to the receive path, waits out the turnaround, lets the encoder
// drive the data phase, then generates SE0,SE0,J itself before releasing.
module usb_tx_bus_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned TA_BITS      = 2,
  parameter int unsigned MAX_TX_BITS  = 600
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_req,
  input  logic rx_busy,
  input  logic enc_dp,
  input  logic enc_dm,
  input  logic tx_done,
  output logic transmitting,
  output logic transmit_eop,
  output logic d_plus_out,
  output logic d_minus_out,
  output logic tx_grant,
  output logic tx_bit_tick,
  output logic tx_complete,
  output logic tx_error
);

  localparam int unsigned BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned WDW = $clog2(MAX_TX_BITS + 1);
  localparam int unsigned TAW = $clog2(TA_BITS + 1);
  // Phase counter doubles as turnaround, EOP and watchdog bit counter.
  localparam int unsigned PW  = (WDW > TAW) ? ((WDW > 2) ? WDW : 2)
                                            : ((TAW > 2) ? TAW : 2);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TURNAROUND = 3'd1,
    DATA       = 3'd2,
    EOP_SE0    = 3'd3,
    EOP_J      = 3'd4
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [BW-1:0]  bcnt;
  logic [PW-1:0]  phase;
  logic           bit_tick;
  logic           err_set;
  logic           complete_set;

  assign bit_tick = (bcnt == BW'(CLKS_PER_BIT - 1));

  // State register; async clear releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the one-cycle event flags for error/complete.
  always_comb begin
    state_next   = state;
    err_set      = 1'b0;
    complete_set = 1'b0;
    case (state)
      IDLE: begin
        if (tx_req && !rx_busy) state_next = TURNAROUND;
      end
      TURNAROUND: begin
        if (rx_busy || !tx_req) begin
          state_next = IDLE;
        end else if (bit_tick && (phase == PW'(TA_BITS - 1))) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (tx_done) begin
          state_next = EOP_SE0;
        end else if (bit_tick && (phase == PW'(MAX_TX_BITS - 1))) begin
          state_next = EOP_SE0;
          err_set    = 1'b1;
        end
      end
      EOP_SE0: begin
        if (bit_tick && (phase == PW'(1))) state_next = EOP_J;
      end
      EOP_J: begin
        if (bit_tick) begin
          state_next   = IDLE;
          complete_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit and phase counters, both cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= '0;
    end else if (state_next != state) begin
      bcnt  <= '0;
      phase <= '0;
    end else begin
      bcnt <= bit_tick ? '0 : bcnt + BW'(1);
      if (bit_tick && (phase != {PW{1'b1}})) phase <= phase + PW'(1);
    end
  end

  // Registered pulses: error in first EOP cycle, complete in first IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_error    <= 1'b0;
      tx_complete <= 1'b0;
    end else begin
      tx_error    <= err_set;
      tx_complete <= complete_set;
    end
  end

  // Moore output decode; only the data-phase line values pass straight through.
  always_comb begin
    transmitting = 1'b0;
    tx_grant     = 1'b0;
    transmit_eop = 1'b0;
    tx_bit_tick  = 1'b0;
    d_plus_out   = 1'b1;
    d_minus_out  = 1'b0;
    case (state)
      DATA: begin
        transmitting = 1'b1;
        tx_grant     = 1'b1;
        tx_bit_tick  = bit_tick;
        d_plus_out   = enc_dp;
        d_minus_out  = enc_dm;
      end
      EOP_SE0: begin
        transmit_eop = 1'b1;
        d_plus_out   = 1'b0;
        d_minus_out  = 1'b0;
      end
      EOP_J: begin
        transmit_eop = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
